// File: rtl/cnn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | cnn_pkg : FSM states and saturating-add helpers shared by the psum accumulator.    |
// | Revision: 1.0                                                                      |
// +------------------------------------------------------------------------------------+
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Helpers work on a fixed wide carrier; callers sign-extend operands of DATA_WIDTH <= MAX_W.
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W+1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t val;
  } sat_res_t;

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic sat_res_t add_sat(input wide_t a, input wide_t b, input wide_t c, input int w);
    sat_res_t r;
    wide_t    sum;
    sum   = a + b + c;
    r.sat = 1'b0;
    r.val = sum;
    if (sum > sat_max(w)) begin
      r.sat = 1'b1;
      r.val = sat_max(w);
    end else if (sum < sat_min(w)) begin
      r.sat = 1'b1;
      r.val = sat_min(w);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_scratch_ram.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | psum_scratch_ram : simple dual-port scratch RAM, 1-cycle registered read.          |
// | Revision: 1.0                                                                      |
// +------------------------------------------------------------------------------------+
module psum_scratch_ram #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | psum_accumulator : sums per-channel partial sums, adds bias, ReLU, emits OFM.      |
// | Revision: 1.0                                                                      |
// +------------------------------------------------------------------------------------+
module psum_accumulator #(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 32,
  parameter int KERNAL_SIZE           = 5,
  parameter int IFM_DEPTH             = 3,
  parameter int RELU                  = 1,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             bias_write,
  input  logic [DATA_WIDTH-1:0]            riscv_data,
  input  logic                             psum_valid,
  input  logic [DATA_WIDTH-1:0]            psum_data,
  output logic                             busy,
  output logic                             ofm_valid,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address,
  output logic [DATA_WIDTH-1:0]            ofm_data,
  output logic                             sat_flag,
  output logic                             done
);
  import cnn_pkg::*;

  localparam int              NPIX     = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int              AW       = ADDRESS_SIZE_NEXT_IFM;
  localparam int              CW       = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam logic [AW-1:0]   PIX_LAST = AW'(NPIX - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(IFM_DEPTH - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
  logic                   sat_q, sat_d;
  logic [DATA_WIDTH-1:0]  bias_q;

  logic                   s1_valid_q, s1_first_q, s1_last_q;
  logic [AW-1:0]          s1_addr_q;
  logic [DATA_WIDTH-1:0]  s1_psum_q;

  logic                   ofm_valid_q;
  logic [AW-1:0]          ofm_address_q;
  logic [DATA_WIDTH-1:0]  ofm_data_q;

  logic                   accept, pix_last, ch_last, launch;
  logic [DATA_WIDTH-1:0]  rd_data, sum_data, ofm_next;
  logic                   scr_wr_en;
  wide_t                  op_rd, op_psum, op_bias;
  sat_res_t               res;
  logic [MAX_W+1-DATA_WIDTH:0] unused_hi;

  assign accept   = (state_q == ST_ACCUM) && psum_valid;
  assign pix_last = (pix_cnt_q == PIX_LAST);
  assign ch_last  = (ch_cnt_q == CH_LAST);
  assign launch   = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && pix_last && ch_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    if (launch) begin
      pix_cnt_d = '0;
      ch_cnt_d  = '0;
    end else if (accept) begin
      if (pix_last) begin
        pix_cnt_d = '0;
        ch_cnt_d  = ch_cnt_q + 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end
  end

  // S1: first pass ignores stale scratch data; only the last pass folds in the bias.
  always_comb begin
    op_rd     = s1_first_q ? '0 : wide_t'($signed(rd_data));
    op_psum   = wide_t'($signed(s1_psum_q));
    op_bias   = s1_last_q ? wide_t'($signed(bias_q)) : '0;
    res       = add_sat(op_rd, op_psum, op_bias, DATA_WIDTH);
    sum_data  = res.val[DATA_WIDTH-1:0];
    unused_hi = res.val[MAX_W+1:DATA_WIDTH];
    ofm_next  = sum_data;
    if ((RELU != 0) && sum_data[DATA_WIDTH-1]) begin
      ofm_next = '0;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (launch) begin
      sat_d = 1'b0;
    end else if (s1_valid_q && res.sat) begin
      sat_d = 1'b1;
    end
  end

  assign scr_wr_en = s1_valid_q && !s1_last_q;

  psum_scratch_ram #(
    .DEPTH      (NPIX),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_scratch (
    .clk       (clk),
    .rd_en_i   (accept),
    .rd_addr_i (pix_cnt_q),
    .rd_data_o (rd_data),
    .wr_en_i   (scr_wr_en),
    .wr_addr_i (s1_addr_q),
    .wr_data_i (sum_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pix_cnt_q     <= '0;
      ch_cnt_q      <= '0;
      sat_q         <= 1'b0;
      bias_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_addr_q     <= '0;
      s1_psum_q     <= '0;
      ofm_valid_q   <= 1'b0;
      ofm_address_q <= '0;
      ofm_data_q    <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      sat_q      <= sat_d;
      s1_valid_q <= accept;
      if (bias_write) begin
        bias_q <= riscv_data;
      end
      if (accept) begin
        s1_addr_q  <= pix_cnt_q;
        s1_psum_q  <= psum_data;
        s1_first_q <= (ch_cnt_q == '0);
        s1_last_q  <= ch_last;
      end
      ofm_valid_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q && s1_last_q) begin
        ofm_address_q <= s1_addr_q;
        ofm_data_q    <= ofm_next;
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign sat_flag    = sat_q;
  assign ofm_valid   = ofm_valid_q;
  assign ofm_address = ofm_address_q;
  assign ofm_data    = ofm_data_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | tb_psum_accumulator : directed bench over four parameterisations of the accumulator.|
// | Revision: 1.0                                                                      |
// +------------------------------------------------------------------------------------+
module tb_psum_accumulator;

  localparam int F_PRE     = 1;
  localparam int F_GAP     = 2;
  localparam int F_RESTART = 4;
  localparam int F_TAIL    = 8;
  localparam int F_SAME    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        bias_write = 1'b0;
  logic [31:0] riscv_data = '0;
  logic        psum_valid = 1'b0;
  logic [31:0] psum_data = '0;
  int          sel = 0;
  int          cyc = 0;

  logic        a_busy, a_valid, a_sat, a_done; logic [1:0] a_addr; logic [31:0] a_data;
  logic        b_busy, b_valid, b_sat, b_done; logic [1:0] b_addr; logic [31:0] b_data;
  logic        c_busy, c_valid, c_sat, c_done; logic [1:0] c_addr; logic [7:0]  c_data;
  logic        d_busy, d_valid, d_sat, d_done; logic [1:0] d_addr; logic [31:0] d_data;

  logic               obs_busy, obs_valid, obs_sat, obs_done;
  logic [1:0]         obs_addr;
  logic signed [31:0] obs_data;

  int     checks = 0;
  int     failures = 0;
  int     done_cnt = 0;
  int     d_wr_cnt = 0;
  longint q_data[$];
  int     q_addr[$];
  int     q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psum_accumulator #(.DATA_WIDTH(32), .IFM_SIZE(4), .KERNAL_SIZE(3), .IFM_DEPTH(3), .RELU(0)) u_a (
    .clk(clk), .reset(reset), .start(start && sel == 0), .bias_write(bias_write && sel == 0),
    .riscv_data(riscv_data), .psum_valid(psum_valid && sel == 0), .psum_data(psum_data),
    .busy(a_busy), .ofm_valid(a_valid), .ofm_address(a_addr), .ofm_data(a_data),
    .sat_flag(a_sat), .done(a_done));

  psum_accumulator #(.DATA_WIDTH(32), .IFM_SIZE(4), .KERNAL_SIZE(3), .IFM_DEPTH(3), .RELU(1)) u_b (
    .clk(clk), .reset(reset), .start(start && sel == 1), .bias_write(bias_write && sel == 1),
    .riscv_data(riscv_data), .psum_valid(psum_valid && sel == 1), .psum_data(psum_data),
    .busy(b_busy), .ofm_valid(b_valid), .ofm_address(b_addr), .ofm_data(b_data),
    .sat_flag(b_sat), .done(b_done));

  psum_accumulator #(.DATA_WIDTH(8), .IFM_SIZE(4), .KERNAL_SIZE(3), .IFM_DEPTH(2), .RELU(0)) u_c (
    .clk(clk), .reset(reset), .start(start && sel == 2), .bias_write(bias_write && sel == 2),
    .riscv_data(riscv_data[7:0]), .psum_valid(psum_valid && sel == 2), .psum_data(psum_data[7:0]),
    .busy(c_busy), .ofm_valid(c_valid), .ofm_address(c_addr), .ofm_data(c_data),
    .sat_flag(c_sat), .done(c_done));

  psum_accumulator #(.DATA_WIDTH(32), .IFM_SIZE(4), .KERNAL_SIZE(3), .IFM_DEPTH(1), .RELU(0)) u_d (
    .clk(clk), .reset(reset), .start(start && sel == 3), .bias_write(bias_write && sel == 3),
    .riscv_data(riscv_data), .psum_valid(psum_valid && sel == 3), .psum_data(psum_data),
    .busy(d_busy), .ofm_valid(d_valid), .ofm_address(d_addr), .ofm_data(d_data),
    .sat_flag(d_sat), .done(d_done));

  always_comb begin
    obs_busy = a_busy; obs_valid = a_valid; obs_sat = a_sat; obs_done = a_done;
    obs_addr = a_addr; obs_data = a_data;
    case (sel)
      1: begin obs_busy = b_busy; obs_valid = b_valid; obs_sat = b_sat; obs_done = b_done;
               obs_addr = b_addr; obs_data = b_data; end
      2: begin obs_busy = c_busy; obs_valid = c_valid; obs_sat = c_sat; obs_done = c_done;
               obs_addr = c_addr; obs_data = {{24{c_data[7]}}, c_data}; end
      3: begin obs_busy = d_busy; obs_valid = d_valid; obs_sat = d_sat; obs_done = d_done;
               obs_addr = d_addr; obs_data = d_data; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (obs_valid) begin
        q_data.push_back(longint'(obs_data));
        q_addr.push_back(int'(obs_addr));
        q_cyc.push_back(cyc);
      end
      if (obs_done) done_cnt++;
      if (u_d.scr_wr_en) d_wr_cnt++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_filter(input int s, input int bias, input int p0, input int pstep, input int depth,
                            input int exp0, input int estep, input int exp_sat, input int flags);
    int exp_cyc[$];
    int t;
    sel = s;
    q_data.delete(); q_addr.delete(); q_cyc.delete();
    done_cnt = 0;
    @(negedge clk);
    if ((flags & F_PRE) != 0) begin
      repeat (3) begin psum_valid = 1'b1; psum_data = 32'd999; @(negedge clk); end
      psum_valid = 1'b0;
    end
    riscv_data = bias; bias_write = 1'b1;
    if ((flags & F_SAME) == 0) begin @(negedge clk); bias_write = 1'b0; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bias_write = 1'b0;
    chk("busy_after_start", longint'(obs_busy), 1);
    for (int p = 0; p < depth; p++) begin
      for (int i = 0; i < 4; i++) begin
        if ((flags & F_RESTART) != 0 && p == 1 && i == 0) begin
          start = 1'b1; @(negedge clk); start = 1'b0;
        end
        if ((flags & F_GAP) != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        psum_valid = 1'b1;
        psum_data  = p0 + i * pstep;
        if (p == depth - 1) exp_cyc.push_back(cyc + 2);
        @(negedge clk);
        psum_valid = 1'b0;
      end
    end
    if ((flags & F_TAIL) != 0) begin psum_valid = 1'b1; psum_data = 32'd555; end
    t = 0;
    while (done_cnt == 0 && t < 20) begin @(negedge clk); t++; end
    psum_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("ofm_count", q_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_data.size()) begin
        chk($sformatf("ofm_data[%0d]", i), q_data[i], exp0 + i * estep);
        chk($sformatf("ofm_addr[%0d]", i), q_addr[i], i);
        chk($sformatf("ofm_latency[%0d]", i), q_cyc[i], exp_cyc[i]);
      end
    end
    chk("sat_flag", longint'(obs_sat), exp_sat);
    chk("busy_after_done", longint'(obs_busy), 0);
    chk("ofm_valid_idle", longint'(obs_valid), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst_valid[%0d]", s), longint'(obs_valid), 0);
      chk($sformatf("rst_busy[%0d]", s), longint'(obs_busy), 0);
      chk($sformatf("rst_data[%0d]", s), longint'(obs_data), 0);
      chk($sformatf("rst_sat_done[%0d]", s), longint'({obs_sat, obs_done}), 0);
    end

    run_filter(0, 10, 1, 1, 3, 13, 3, 0, F_TAIL);
    run_filter(0, -100, 1, 1, 3, -97, 3, 0, 0);
    run_filter(1, -100, 1, 1, 3, 0, 0, 0, 0);
    run_filter(2, 0, 100, 0, 2, 127, 0, 1, 0);
    run_filter(2, 0, -100, 0, 2, -128, 0, 1, 0);
    run_filter(0, 10, 1, 1, 3, 13, 3, 0, F_PRE | F_GAP | F_RESTART);

    // Abandon a filter partway through the second pass, then restart cleanly.
    sel = 0;
    @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) begin psum_valid = 1'b1; psum_data = 32'd50; @(negedge clk); end
    psum_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", longint'(obs_busy), 0);
    chk("midrst_valid", longint'(obs_valid), 0);
    run_filter(0, 0, 1, 0, 3, 3, 0, 0, 0);

    d_wr_cnt = 0;
    run_filter(3, 5, 7, 0, 1, 12, 0, 0, F_SAME);
    chk("depth1_scratch_writes", d_wr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
